// File: rtl/fetch_if.sv
// fetch_if
//   Groups the fetch stage's two handshakes: the instruction-memory read
//   channel (req/ready/rvalid) and the decode-facing presentation/redirect
//   channel.
//   master : the fetch unit (drives imem_req/imem_addr and PC/instr/instrValid)
//   slave  : the environment (memory + decode) driving the remaining signals
interface fetch_if;
    // instruction memory read channel
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    // decode channel
    logic [15:0] PC;
    logic [15:0] instr;
    logic        instrValid;
    logic        stall;
    logic [1:0]  brSel;
    logic        brEx;
    logic [15:0] bxTarget;

    modport master (
        output imem_req, imem_addr, PC, instr, instrValid,
        input  imem_ready, imem_rvalid, imem_rdata, stall, brSel, brEx, bxTarget
    );

    modport slave (
        input  imem_req, imem_addr, PC, instr, instrValid,
        output imem_ready, imem_rvalid, imem_rdata, stall, brSel, brEx, bxTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage feeding decode. Owns the fetch PC, issues 16-bit
//   reads to instruction memory, buffers up to two fetched {pc, instr} pairs
//   and presents the oldest one to decode. Redirects from decode (brSel/brEx)
//   flush the buffer, retarget fetch, and mark in-flight reads for discard.
//
//   Ports
//     clk, reset  : clock, synchronous active-high reset
//     bus.master  : imem_req/imem_addr out, imem_ready/imem_rvalid/imem_rdata in;
//                   PC/instr/instrValid out, stall/brSel/brEx/bxTarget in
//
//   Parameters
//     RESET_PC  : fetch address after reset
//     NOP_INSTR : instruction shown to decode while nothing is valid
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'hBF00
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic [1:0][15:0] buf_pc_q,   buf_pc_d;    // entry 0 is the head
    logic [1:0][15:0] buf_ins_q,  buf_ins_d;
    logic [1:0]       count_q,    count_d;     // buffered entries, 0..2
    logic [1:0]       inflight_q, inflight_d;  // accepted, not yet returned
    logic [1:0]       drop_q,     drop_d;      // oldest in-flight reads to discard
    logic [1:0][15:0] req_pc_q,   req_pc_d;    // addresses of in-flight reads, oldest at 0

    // ------------------------------------------------------------------
    // Per-cycle control
    // ------------------------------------------------------------------
    logic        head_valid;
    logic [15:0] head_pc;
    logic [15:0] head_ins;
    logic        redirect;
    logic        pop;
    logic        resp;
    logic        push;
    logic [2:0]  credit;
    logic        req;
    logic        accept;
    logic        wr_sel;
    logic        rq_sel;
    logic [15:0] br_base;
    logic [15:0] target;

    assign head_valid = (count_q != 2'd0);
    assign head_pc    = buf_pc_q[0];
    assign head_ins   = buf_ins_q[0];

    // Decode's branch decision only counts when it actually consumes the head.
    assign redirect = head_valid && !bus.stall && (bus.brEx || (bus.brSel != 2'b11));
    assign pop      = head_valid && !bus.stall && !redirect;

    // A response with nothing outstanding belongs to a request from before
    // reset and is ignored entirely.
    assign resp = bus.imem_rvalid && (inflight_q != 2'd0);
    // A response landing in a redirect cycle is wrong-path: the buffer it would
    // join is being cleared.
    assign push = resp && (drop_q == 2'd0) && !redirect;

    // Credit: every accepted read must have a buffer slot waiting for it,
    // counting the slot the head frees this cycle.
    assign credit = {1'b0, count_q} + {1'b0, inflight_q} - {2'b00, pop};
    assign req    = !reset && !redirect && (credit < 3'd2);
    assign accept = req && bus.imem_ready;

    // Write slot for a pushed entry is (count - pop); for the PC queue it is
    // (inflight - resp). Both results are 0 or 1 whenever a write happens,
    // which reduces to the LSB xor the decrement.
    assign wr_sel = count_q[0] ^ pop;
    assign rq_sel = inflight_q[0] ^ resp;

    // Branch target, relative to the presented instruction's PC + 4.
    always_comb begin
        br_base = head_pc + 16'd4;
        target  = br_base;
        if (bus.brEx)
            target = bus.bxTarget & 16'hFFFE;
        else if (bus.brSel == 2'b01)
            target = br_base + {{7{head_ins[7]}}, head_ins[7:0], 1'b0};
        else
            target = br_base + {{4{head_ins[10]}}, head_ins[10:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        buf_pc_d   = buf_pc_q;
        buf_ins_d  = buf_ins_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        req_pc_d   = req_pc_q;

        // instruction buffer
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                buf_pc_d[0]  = buf_pc_q[1];
                buf_ins_d[0] = buf_ins_q[1];
            end
            if (push) begin
                buf_pc_d[wr_sel]  = req_pc_q[0];
                buf_ins_d[wr_sel] = bus.imem_rdata;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end

        // in-flight address queue; the oldest entry retires on every response,
        // dropped or not
        if (resp)
            req_pc_d[0] = req_pc_q[1];
        if (accept)
            req_pc_d[rq_sel] = fetch_pc_q;
        inflight_d = inflight_q + {1'b0, accept} - {1'b0, resp};

        // wrong-path discard count; no request is accepted in a redirect cycle
        if (redirect)
            drop_d = inflight_q - {1'b0, resp};
        else if (resp && (drop_q != 2'd0))
            drop_d = drop_q - 2'd1;

        // fetch address
        if (redirect)
            fetch_pc_d = target;
        else if (accept)
            fetch_pc_d = fetch_pc_q + 16'd2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            buf_pc_q   <= '0;
            buf_ins_q  <= '0;
            count_q    <= 2'd0;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            req_pc_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_ins_q  <= buf_ins_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.instrValid = head_valid;
    assign bus.PC         = head_valid ? head_pc  : 16'h0000;
    assign bus.instr      = head_valid ? head_ins : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed scenarios plus a randomized run against an architectural model:
//   the model tracks only "which PC should decode see next" and the memory
//   image, and never looks at credits, buffer slots or drop counts.
module tb_fetch_unit;
    localparam logic [15:0] NOP = 16'hBF00;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_if bus ();

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        int          due;
    } rq_t;
    rq_t pend[$];

    logic [15:0] ovr [logic [15:0]];
    bit  hashed   = 1'b0;
    int  lat_min  = 0;
    int  lat_max  = 0;
    bit  rdy_rand = 1'b0;
    bit  rdy_off  = 1'b0;

    logic        req_s;
    logic        acc;
    logic [15:0] acc_addr;

    function automatic logic [15:0] mem(input logic [15:0] a);
        if (ovr.exists(a)) return ovr[a];
        if (hashed) return {a[7:0], a[15:8]} ^ 16'h5A5A;
        return a;
    endfunction

    // One clock of the memory model. Called at a negedge with decode inputs
    // already set; returns at the next negedge.
    task automatic tick();
        rq_t r;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend[0].d;
            void'(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 16'($urandom);
        end
        bus.imem_ready = rdy_off ? 1'b0 : (rdy_rand ? ($urandom_range(3) != 0) : 1'b1);
        #1;
        req_s    = bus.imem_req;
        acc      = bus.imem_req && bus.imem_ready;
        acc_addr = bus.imem_addr;
        if (acc) begin
            r.a   = acc_addr;
            r.d   = mem(acc_addr);
            r.due = cyc + 1 + lat_min + int'($urandom_range(lat_max));
            pend.push_back(r);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_decode();
        bus.stall    = 1'b0;
        bus.brSel    = 2'b11;
        bus.brEx     = 1'b0;
        bus.bxTarget = 16'h0000;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_decode();
        pend.delete();
        repeat (n) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        idle_decode();
        while (n < budget) begin
            if (bus.instrValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic run_to(input logic [15:0] pc, input int budget, output bit ok);
        ok = 1'b0;
        idle_decode();
        for (int i = 0; i < budget; i++) begin
            if (bus.instrValid === 1'b1 && bus.PC === pc) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic        ev;
        logic [15:0] epc;
        ovr.delete(); hashed = 1'b0; lat_min = 0; lat_max = 0; rdy_rand = 1'b0; rdy_off = 1'b0;
        reset = 1'b1;
        idle_decode();
        pend.delete();
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                checks++;
                if (bus.instrValid !== 1'b0 || bus.PC !== 16'h0000 || bus.instr !== NOP) begin
                    failures++;
                    $display("FAIL reset_outputs got v=%b pc=%h ins=%h want v=0 pc=0000 ins=%h",
                             bus.instrValid, bus.PC, bus.instr, NOP);
                end
            end
            tick();
            checks++;
            if (req_s !== 1'b0) begin
                failures++;
                $display("FAIL reset_req cycle=%0d got=%b want=0", i, req_s);
            end
        end
        reset = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 6; k++) begin
            ev  = (k >= 2);
            epc = ev ? 16'(2 * (k - 2)) : 16'h0000;
            checks++;
            if (bus.instrValid !== ev || bus.PC !== epc || bus.instr !== (ev ? epc : NOP)) begin
                failures++;
                $display("FAIL seq_present cycle=%0d got v=%b pc=%h ins=%h want v=%b pc=%h",
                         k, bus.instrValid, bus.PC, bus.instr, ev, epc);
            end
            tick();
            checks++;
            if (acc !== 1'b1 || acc_addr !== 16'(2 * k)) begin
                failures++;
                $display("FAIL seq_request cycle=%0d got req=%b addr=%h want req=1 addr=%h",
                         k, acc, acc_addr, 16'(2 * k));
            end
        end
    endtask

    task automatic test_cond_branch();
        bit ok;
        int n;
        ovr.delete();
        ovr[16'h0010] = 16'hD0FC;
        do_reset(2);
        run_to(16'h0010, 40, ok);
        checks++;
        if (!ok || bus.instr !== 16'hD0FC) begin
            failures++;
            $display("FAIL bcond_reach got ok=%b ins=%h want ok=1 ins=d0fc", ok, bus.instr);
        end
        bus.brSel = 2'b01;
        tick();
        checks++;
        if (req_s !== 1'b0) begin
            failures++;
            $display("FAIL bcond_req_in_redirect got=%b want=0", req_s);
        end
        idle_decode();
        checks++;
        if (bus.instrValid !== 1'b0) begin
            failures++;
            $display("FAIL bcond_flush got v=%b pc=%h want v=0", bus.instrValid, bus.PC);
        end
        tick();
        checks++;
        if (acc !== 1'b1 || acc_addr !== 16'h000C) begin
            failures++;
            $display("FAIL bcond_target_req got req=%b addr=%h want req=1 addr=000c", acc, acc_addr);
        end
        wait_valid(10, ok, n);
        checks++;
        if (!ok || n != 1 || bus.PC !== 16'h000C || bus.instr !== 16'h000C) begin
            failures++;
            $display("FAIL bcond_target got ok=%b wait=%0d pc=%h ins=%h want ok=1 wait=1 pc=000c ins=000c",
                     ok, n, bus.PC, bus.instr);
        end
        tick();
        wait_valid(10, ok, n);
        checks++;
        if (!ok || bus.PC !== 16'h000E) begin
            failures++;
            $display("FAIL bcond_after got ok=%b pc=%h want pc=000e", ok, bus.PC);
        end
    endtask

    task automatic test_b_bx();
        bit ok;
        int n;
        ovr.delete();
        ovr[16'h0020] = 16'hE7FE;
        do_reset(2);
        run_to(16'h0020, 60, ok);
        bus.brSel = 2'b10;
        tick();
        wait_valid(10, ok, n);
        checks++;
        if (!ok || n != 2 || bus.PC !== 16'h0020 || bus.instr !== 16'hE7FE) begin
            failures++;
            $display("FAIL b_target got ok=%b wait=%0d pc=%h ins=%h want ok=1 wait=2 pc=0020 ins=e7fe",
                     ok, n, bus.PC, bus.instr);
        end
        bus.brEx     = 1'b1;
        bus.brSel    = 2'b01;
        bus.bxTarget = 16'h0041;
        tick();
        wait_valid(10, ok, n);
        checks++;
        if (!ok || bus.PC !== 16'h0040 || bus.instr !== 16'h0040) begin
            failures++;
            $display("FAIL bx_target got ok=%b pc=%h ins=%h want pc=0040 ins=0040", ok, bus.PC, bus.instr);
        end
    endtask

    task automatic test_stall();
        bit          ok;
        logic [15:0] p;
        logic [15:0] i0;
        ovr.delete();
        do_reset(2);
        run_to(16'h0008, 40, ok);
        p  = bus.PC;
        i0 = bus.instr;
        bus.stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.instrValid !== 1'b1 || bus.PC !== p || bus.instr !== i0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got v=%b pc=%h ins=%h want pc=%h ins=%h",
                         k, bus.instrValid, bus.PC, bus.instr, p, i0);
            end
            tick();
            checks++;
            if (req_s !== 1'b0) begin
                failures++;
                $display("FAIL stall_req cycle=%0d got=%b want=0", k, req_s);
            end
        end
        bus.stall = 1'b0;
        tick();
        checks++;
        if (acc !== 1'b1 || acc_addr !== p + 16'd4) begin
            failures++;
            $display("FAIL stall_resume got req=%b addr=%h want req=1 addr=%h", acc, acc_addr, p + 16'd4);
        end
        for (int j = 1; j <= 4; j++) begin
            checks++;
            if (bus.instrValid !== 1'b1 || bus.PC !== p + 16'(2 * j)) begin
                failures++;
                $display("FAIL stall_stream j=%0d got v=%b pc=%h want v=1 pc=%h",
                         j, bus.instrValid, bus.PC, p + 16'(2 * j));
            end
            tick();
        end
    endtask

    task automatic test_stall_redirect();
        bit ok;
        int n;
        ovr.delete();
        ovr[16'h0030] = 16'hD004;
        do_reset(2);
        run_to(16'h0030, 60, ok);
        bus.stall = 1'b1;
        bus.brSel = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.instrValid !== 1'b1 || bus.PC !== 16'h0030) begin
                failures++;
                $display("FAIL stall_br_ignored cycle=%0d got v=%b pc=%h want v=1 pc=0030",
                         k, bus.instrValid, bus.PC);
            end
        end
        bus.stall = 1'b0;
        tick();
        wait_valid(10, ok, n);
        checks++;
        if (!ok || bus.PC !== 16'h003C) begin
            failures++;
            $display("FAIL stall_br_taken got ok=%b pc=%h want pc=003c", ok, bus.PC);
        end
        tick();
        wait_valid(10, ok, n);
        checks++;
        if (!ok || bus.PC !== 16'h003E) begin
            failures++;
            $display("FAIL stall_br_once got ok=%b pc=%h want pc=003e", ok, bus.PC);
        end
    endtask

    task automatic test_wrap();
        bit          ok;
        int          n;
        logic [15:0] e;
        ovr.delete();
        do_reset(2);
        run_to(16'h0004, 40, ok);
        bus.brEx     = 1'b1;
        bus.bxTarget = 16'hFFFD;
        tick();
        for (int j = 0; j < 4; j++) begin
            if (j > 0) tick();
            wait_valid(10, ok, n);
            e = 16'hFFFC + 16'(2 * j);
            checks++;
            if (!ok || bus.PC !== e || bus.instr !== e) begin
                failures++;
                $display("FAIL wrap j=%0d got ok=%b pc=%h ins=%h want pc=%h", j, ok, bus.PC, bus.instr, e);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int n;
        ovr.delete();
        do_reset(2);
        lat_min = 10;
        tick();
        tick();
        checks++;
        if (pend.size() != 2) begin
            failures++;
            $display("FAIL midflight_setup got outstanding=%0d want=2", pend.size());
        end
        reset = 1'b1;
        foreach (pend[i]) pend[i].due = 1 << 30;
        tick();
        checks++;
        if (req_s !== 1'b0) begin
            failures++;
            $display("FAIL midflight_reset_req got=%b want=0", req_s);
        end
        tick();
        reset   = 1'b0;
        cyc     = 0;
        rdy_off = 1'b1;
        foreach (pend[i]) begin
            pend[i].due = i;
            pend[i].d   = 16'hDEAD;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.instrValid !== 1'b0 || bus.PC !== 16'h0000 || bus.instr !== NOP) begin
                failures++;
                $display("FAIL midflight_late_ignored cycle=%0d got v=%b pc=%h ins=%h want v=0",
                         k, bus.instrValid, bus.PC, bus.instr);
            end
            tick();
        end
        rdy_off = 1'b0;
        lat_min = 0;
        wait_valid(10, ok, n);
        checks++;
        if (!ok || bus.PC !== 16'h0000 || bus.instr !== 16'h0000) begin
            failures++;
            $display("FAIL midflight_first got ok=%b pc=%h ins=%h want pc=0000 ins=0000",
                     ok, bus.PC, bus.instr);
        end
        tick();
        wait_valid(10, ok, n);
        checks++;
        if (!ok || bus.PC !== 16'h0002) begin
            failures++;
            $display("FAIL midflight_second got ok=%b pc=%h want pc=0002", ok, bus.PC);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] ei;
        logic [15:0] pp;
        logic [15:0] pi;
        bit          held;
        bit          st;
        bit          br;
        int          off;
        int          presented;
        ovr.delete();
        hashed   = 1'b1;
        lat_max  = 3;
        rdy_rand = 1'b1;
        do_reset(2);
        exp_pc    = 16'h0000;
        held      = 1'b0;
        presented = 0;
        pp        = 16'h0000;
        pi        = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            if (bus.instrValid === 1'b0) begin
                checks++;
                if (bus.PC !== 16'h0000 || bus.instr !== NOP) begin
                    failures++;
                    $display("FAIL rnd_idle cycle=%0d got pc=%h ins=%h want pc=0000 ins=%h",
                             c, bus.PC, bus.instr, NOP);
                end
            end
            if (held) begin
                checks++;
                if (bus.instrValid !== 1'b1 || bus.PC !== pp || bus.instr !== pi) begin
                    failures++;
                    $display("FAIL rnd_hold cycle=%0d got v=%b pc=%h ins=%h want pc=%h ins=%h",
                             c, bus.instrValid, bus.PC, bus.instr, pp, pi);
                end
            end
            st = ($urandom_range(3) == 0);
            br = ($urandom_range(7) == 0);
            bus.stall    = st;
            bus.bxTarget = 16'($urandom);
            if (st) begin
                bus.brSel = 2'($urandom_range(3));
                bus.brEx  = ($urandom_range(3) == 0);
            end else if (br) begin
                bus.brSel = 2'($urandom_range(2));
                bus.brEx  = ($urandom_range(2) == 0);
            end else begin
                bus.brSel = 2'b11;
                bus.brEx  = 1'b0;
            end
            if (bus.instrValid === 1'b1 && !st) begin
                ei = mem(exp_pc);
                checks++;
                if (bus.PC !== exp_pc || bus.instr !== ei) begin
                    failures++;
                    $display("FAIL rnd_stream cycle=%0d got pc=%h ins=%h want pc=%h ins=%h",
                             c, bus.PC, bus.instr, exp_pc, ei);
                end
                presented++;
                if (bus.brEx) begin
                    exp_pc = bus.bxTarget & 16'hFFFE;
                end else if (bus.brSel == 2'b01) begin
                    off = int'(ei[7:0]);
                    if (off > 127) off -= 256;
                    exp_pc = 16'(int'(exp_pc) + 4 + 2 * off);
                end else if (bus.brSel != 2'b11) begin
                    off = int'(ei[10:0]);
                    if (off > 1023) off -= 2048;
                    exp_pc = 16'(int'(exp_pc) + 4 + 2 * off);
                end else begin
                    exp_pc = exp_pc + 16'd2;
                end
            end
            held = (bus.instrValid === 1'b1) && st;
            pp   = bus.PC;
            pi   = bus.instr;
            tick();
        end
        checks++;
        if (presented < 300) begin
            failures++;
            $display("FAIL rnd_progress got presented=%0d want>=300", presented);
        end
        hashed   = 1'b0;
        lat_max  = 0;
        rdy_rand = 1'b0;
    endtask

    initial begin
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        idle_decode();
        @(negedge clk);
        test_reset();
        test_cond_branch();
        test_b_bx();
        test_stall();
        test_stall_redirect();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
